// File: rtl/mux7_arb_pkg.sv
// rtl/mux7_arb_pkg.sv - shared types and constants for the 7-way round-robin mux arbiter
package mux7_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [2:0] SEL_IDLE = 3'b111;
  localparam int         NUM_REQ  = 7;

  function automatic logic [6:0] onehot7(input logic [2:0] idx);
    return 7'b0000001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick7.sv
// rtl/rr_pick7.sv - wrapped priority scan: first set req bit after index last, wrapping 6->0
module rr_pick7
  import mux7_arb_pkg::*;
(
  input  logic [6:0] req,
  input  logic [2:0] last,
  output logic [2:0] pick,
  output logic       any
);

  always_comb begin
    int w_start;
    int w_idx;
    pick    = 3'd0;
    any     = 1'b0;
    w_start = (last >= 3'd6) ? 0 : int'(last) + 1;
    w_idx   = 0;
    // Scan from farthest to nearest so the nearest requester is written last and wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (w_start + k) % NUM_REQ;
      if (req[w_idx]) begin
        pick = 3'(w_idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux7_rr_arbiter.sv
// rtl/mux7_rr_arbiter.sv - round-robin owner of a shared 7:1 mux; break-before-make grants
// Optional forced release after HOLD_MAX cycles when MUX7_ARB_TIMEOUT_EN is defined.
module mux7_rr_arbiter
  import mux7_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] req,
  input  logic       done,
  input  logic [6:0] data_in,
  output logic [6:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       data_out,
  output logic       timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be within 2..255");
  end

  state_t     r_state;
  logic [6:0] r_grant;
  logic [2:0] r_sel;
  logic [2:0] r_last;
  logic       r_busy;

  logic [2:0] w_pick;
  logic       w_any;
  logic [7:0] w_req_pad;
  logic [7:0] w_data_pad;
  logic       w_owner_req;
  logic       w_force;
  logic       w_release;

  rr_pick7 u_pick (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

  // Index 7 (idle code) lands on the padded zero bit
  assign w_req_pad   = {1'b0, req};
  assign w_data_pad  = {1'b0, data_in};
  assign w_owner_req = w_req_pad[r_sel];
  assign w_release   = done | ~w_owner_req | w_force;

`ifdef MUX7_ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  assign w_force = (r_hold == 8'(HOLD_MAX - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        r_hold <= 8'd0;
      end else if (w_release) begin
        r_hold    <= 8'd0;
        r_timeout <= w_force & ~done & w_owner_req;
      end else begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 7'd0;
      r_sel   <= SEL_IDLE;
      r_busy  <= 1'b0;
      r_last  <= 3'd6;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= onehot7(w_pick);
            r_sel   <= w_pick;
            r_busy  <= 1'b1;
            r_last  <= w_pick;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_grant <= 7'd0;
            r_sel   <= SEL_IDLE;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign sel      = r_sel;
  assign busy     = r_busy;
  assign data_out = w_data_pad[r_sel] & r_busy;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// tb/tb_mux7_rr_arbiter.sv - directed self-checking bench for mux7_rr_arbiter (honours MUX7_ARB_TIMEOUT_EN)
module tb_mux7_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] req;
  logic       done;
  logic [6:0] data_in;
  logic [6:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       data_out;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mux7_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .data_in  (data_in),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .data_out (data_out),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [6:0] g, input logic [2:0] s, input logic b);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_sel"},   32'(sel),   32'(s));
    chk({tag, "_busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    int busy_cnt;
    int to_cnt;

    reset   = 1'b1;
    req     = 7'd0;
    done    = 1'b0;
    data_in = 7'd0;
    tick();
    chk_state("reset", 7'd0, 3'd7, 1'b0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);

    // First grant goes to 0, one cycle after req is sampled
    reset   = 1'b0;
    req     = 7'b0000001;
    data_in = 7'b0000001;
    chk_state("pre_grant0", 7'd0, 3'd7, 1'b0);
    tick();
    chk_state("grant0", 7'b0000001, 3'd0, 1'b1);
    chk("grant0_dout1", 32'(data_out), 32'd1);
    data_in = 7'b1111110;
    #1;
    chk("grant0_dout0", 32'(data_out), 32'd0);

    // Rotation 0 -> 3 -> 6 -> 0 with an idle gap each time
    req     = 7'b1001001;
    data_in = 7'b1111111;
    done    = 1'b1;
    tick();
    chk_state("gap0", 7'd0, 3'd7, 1'b0);
    chk("gap0_dout", 32'(data_out), 32'd0);
    done = 1'b0;
    tick();
    chk_state("grant3", 7'b0001000, 3'd3, 1'b1);
    chk("grant3_dout", 32'(data_out), 32'd1);
    done = 1'b1;
    tick();
    chk_state("gap3", 7'd0, 3'd7, 1'b0);
    done = 1'b0;
    tick();
    chk_state("grant6", 7'b1000000, 3'd6, 1'b1);
    done = 1'b1;
    tick();
    chk_state("gap6", 7'd0, 3'd7, 1'b0);
    done = 1'b0;
    tick();
    chk_state("wrap0", 7'b0000001, 3'd0, 1'b1);
    req = 7'd0;
    tick();
    chk_state("drop0", 7'd0, 3'd7, 1'b0);

    // Lone requester 5 regranted after each idle gap
    req = 7'b0100000;
    tick();
    chk_state("solo5_a", 7'b0100000, 3'd5, 1'b1);
    done = 1'b1;
    tick();
    chk("solo5_gap_a", 32'(sel), 32'd7);
    done = 1'b0;
    tick();
    chk("solo5_b", 32'(sel), 32'd5);
    done = 1'b1;
    tick();
    chk("solo5_gap_b", 32'(sel), 32'd7);
    done = 1'b0;
    tick();
    chk("solo5_c", 32'(sel), 32'd5);
    req = 7'd0;
    tick();
    chk_state("solo5_end", 7'd0, 3'd7, 1'b0);

    // Owner 2 drops its request; next search starts at 3
    req = 7'b0000100;
    tick();
    chk_state("grant2", 7'b0000100, 3'd2, 1'b1);
    req = 7'b0001011;
    tick();
    chk_state("drop2", 7'd0, 3'd7, 1'b0);
    chk("drop2_timeout", 32'(timeout), 32'd0);
    tick();
    chk_state("resume3", 7'b0001000, 3'd3, 1'b1);
    req = 7'd0;
    tick();
    chk_state("resume3_end", 7'd0, 3'd7, 1'b0);

    // Long hold by requester 1 with done low
    req = 7'b0000010;
    tick();
    chk_state("hold1", 7'b0000010, 3'd1, 1'b1);
`ifdef MUX7_ARB_TIMEOUT_EN
    busy_cnt = 1;
    to_cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (timeout) to_cnt++;
    end
    chk("hold1_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("hold1_no_early_to", 32'(to_cnt), 32'd0);
    tick();
    chk_state("hold1_forced", 7'd0, 3'd7, 1'b0);
    chk("hold1_timeout", 32'(timeout), 32'd1);
    tick();
    chk_state("hold1_regrant", 7'b0000010, 3'd1, 1'b1);
    chk("hold1_timeout_clr", 32'(timeout), 32'd0);
`else
    busy_cnt = 0;
    to_cnt   = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy && grant == 7'b0000010) busy_cnt++;
      if (timeout) to_cnt++;
    end
    chk("hold1_busy_cycles", 32'(busy_cnt), 32'd100);
    chk("hold1_timeout", 32'(to_cnt), 32'd0);
`endif
    done = 1'b1;
    tick();
    chk_state("hold1_done", 7'd0, 3'd7, 1'b0);
    chk("hold1_done_timeout", 32'(timeout), 32'd0);

    // done while idle is ignored
    req = 7'd0;
    tick();
    chk_state("idle_done", 7'd0, 3'd7, 1'b0);
    done = 1'b0;

    // Reset mid-grant of owner 4; first grant afterwards is index 0
    req = 7'b0010000;
    tick();
    chk_state("grant4", 7'b0010000, 3'd4, 1'b1);
    req   = 7'b1111111;
    reset = 1'b1;
    tick();
    chk_state("mid_reset", 7'd0, 3'd7, 1'b0);
    chk("mid_reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();
    chk_state("post_reset", 7'b0000001, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux7_rr_arbiter.md
Name: mux7_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 7-to-1 single-bit mux between 7 requesters.
- Grants one requester at a time, holds the grant until that requester finishes, and drives the 3-bit mux select code.
- Also outputs the muxed data bit, gated by the grant.
- Sits between the requester logic (switch/key-driven in lab top levels) and the shared mux path feeding LEDR.

Parameters:
- HOLD_MAX, 16, maximum grant length in cycles; used only when MUX7_ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  7  request vector; req[i] high = requester i wants the mux.
- done  input  1  current owner finished; sampled only while a grant is active.
- data_in  input  7  mux data inputs; data_in[i] belongs to requester i.
- grant  output  7  one-hot grant, registered; all zero when idle.
- sel  output  3  registered mux select; 3'b000..3'b110 = granted index; 3'b111 = idle/no owner.
- busy  output  1  registered; high while a grant is active.
- data_out  output  1  combinational: data_in[sel] when busy, else 1'b0.
- timeout  output  1  registered one-cycle pulse when a grant is force-released; constant 0 without the macro.

Behaviour:
- Reset (synchronous, checked first each edge): grant=0, sel=3'b111, busy=0, timeout=0, hold counter=0, last pointer=6. With last=6, the first search starts at index 0. State=IDLE.
- Reset mid-grant drops the grant on the next edge with no done/timeout pulse.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, pick the first set bit scanning last+1, last+2, ... with wrap 6->0.
  - On the next edge: grant=onehot(pick), sel=pick, busy=1, last=pick, state=GRANT.
  - Latency from req sampled high to grant visible: 1 cycle.
- GRANT:
  - Release condition: done==1, OR req[sel]==0, OR (macro only) hold counter reaches HOLD_MAX-1.
  - On release the next edge sets grant=0, sel=3'b111, busy=0, state=IDLE.
  - Break-before-make: at least one idle cycle between consecutive grants, even when others are requesting.
  - Requests from others during GRANT are ignored until IDLE; no preemption.
- Fairness: after owner i releases, the next grant goes to the nearest requesting index above i (wrapping). If only i is still requesting, i is regranted after the idle gap.
- Simultaneous events: done and timeout in the same cycle count as a normal release, so timeout stays 0. done while in IDLE is ignored.
- data_out: pure combinational mux on the registered sel. Code 3'b111 never selects data and yields 0.
- Invariants: grant is zero or one-hot; busy == (grant != 0); sel==3'b111 exactly when busy==0.

Optional Feature:
- Macro: MUX7_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle.
  - When it reaches HOLD_MAX-1 with no other release condition, the grant is force-released.
  - timeout pulses high for the one cycle where busy falls.
  - A grant therefore lasts at most HOLD_MAX cycles.
- Undefined:
  - No counter logic.
  - timeout is tied to 0.
  - A grant lasts until done or until the owner drops its request.

Decomposition:
- Package mux7_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam SEL_IDLE = 3'b111
  - localparam NUM_REQ = 7
- Sub-module rr_pick7 (combinational):
  - Inputs: req[6:0], last[2:0].
  - Outputs: pick[2:0], any.
  - Implements the wrapped priority scan so it can be tested exhaustively on its own (7 x 128 cases).

Test Plan:
- Reset then req=7'b0000001 -> grant=7'b0000001, sel=0, busy=1 exactly one cycle after req is sampled; data_out follows data_in[0].
- Owner 0 active, req=7'b1001001, pulse done -> one idle cycle (sel=7, busy=0, data_out=0), then grant=7'b0001000, sel=3. Repeat: next grant goes to 6, then wraps to 0.
- Only req[5] held continuously, done pulsed each grant -> grant 5 re-issued after every one-cycle idle gap; sel toggles 5,7,5,7.
- Owner 2 drops req[2] while done=0 -> release on the next edge; timeout=0; arbitration resumes from index 3.
- Macro defined, HOLD_MAX=4, req[1] held, done=0 -> busy high exactly 4 cycles; timeout pulses with the falling busy; regrant after the idle cycle. Macro undefined, same stimulus -> grant held for 100 cycles, timeout stays 0.
- Reset asserted mid-grant of owner 4 -> next edge grant=0, sel=7, busy=0; with req=7'b1111111 the first grant after reset is index 0.
